// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: synchronizes the receiver's done flag, queues each frame in a
// first-word-fall-through FIFO and applies baud/parity changes only while no frame is active.
module uart_rx_ctrl #(
  parameter int DEPTH     = 8,
  parameter int ERR_CNT_W = 8,
  parameter bit DROP_ERR  = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_wr,
  input  logic [1:0]                   cfg_baud,
  input  logic [1:0]                   cfg_parity,
  output logic                         cfg_busy,
  output logic [1:0]                   baud_rate,
  output logic [1:0]                   parity_type,
  input  logic                         rx_done,
  input  logic [7:0]                   rx_data,
  input  logic [2:0]                   rx_error,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [7:0]                   m_data,
  output logic [2:0]                   m_error,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic [ERR_CNT_W-1:0]         err_count,
  input  logic                         clr_status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_CFG
  } state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic [1:0]           baud_q, baud_d;
  logic [1:0]           parity_q, parity_d;
  logic [1:0]           pend_baud_q, pend_baud_d;
  logic [1:0]           pend_parity_q, pend_parity_d;
  logic                 busy_q, busy_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [10:0]          mem_q [DEPTH];

  logic        frame_edge;
  logic        frame_err;
  logic        want_push;
  logic        full;
  logic        do_pop;
  logic        push_en;
  logic        ovf_event;
  logic [10:0] head;

  assign frame_edge = s2_q & ~s3_q;
  assign frame_err  = |rx_error;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign do_pop     = m_valid & m_ready;
  assign want_push  = frame_edge & ~(DROP_ERR & frame_err);
  assign push_en    = want_push & (~full | do_pop);
  assign ovf_event  = want_push & full & ~do_pop;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    parity_d      = parity_q;
    pend_baud_d   = pend_baud_q;
    pend_parity_d = pend_parity_q;
    busy_d        = busy_q;

    if (cfg_wr) begin
      pend_baud_d   = cfg_baud;
      pend_parity_d = cfg_parity;
      busy_d        = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_edge) begin
          state_d = ST_FRAME;
        end else if (busy_q) begin
          state_d = ST_CFG;
        end
      end
      ST_FRAME: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_CFG: begin
        // A write landing in this very cycle stays pending for the next CFG visit.
        baud_d   = pend_baud_q;
        parity_d = pend_parity_q;
        if (!cfg_wr) begin
          busy_d = 1'b0;
        end
        state_d = frame_edge ? ST_FRAME : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push_en) - CNT_W'(do_pop);
    overflow_d  = overflow_q;
    err_count_d = err_count_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (clr_status) begin
      overflow_d = 1'b0;
    end

    if (clr_status) begin
      err_count_d = frame_edge && frame_err ? ERR_CNT_W'(1) : '0;
    end else if (frame_edge && frame_err && !(&err_count_q)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // Sync flops reset high so a done flag already asserted at release is not seen as a new frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      s3_q          <= 1'b1;
      baud_q        <= 2'b10;
      parity_q      <= 2'b10;
      pend_baud_q   <= 2'b10;
      pend_parity_q <= 2'b10;
      busy_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= rx_done;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      baud_q        <= baud_d;
      parity_q      <= parity_d;
      pend_baud_q   <= pend_baud_d;
      pend_parity_q <= pend_parity_d;
      busy_q        <= busy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      err_count_q   <= err_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= {rx_error, rx_data};
    end
  end

  assign cfg_busy    = busy_q;
  assign baud_rate   = baud_q;
  assign parity_type = parity_q;
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? head[7:0] : 8'h00;
  assign m_error     = m_valid ? head[10:8] : 3'b000;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign err_count   = err_count_q;

endmodule
